slave_endp_mux: RTL and testbench

Per-endpoint register bank and selector that sits directly downstream of the USB slave controller. It supplies the selected endpoint's control nibble to the controller and consumes the controller's end-of-transaction strobes: clear-ready, error-latch and transaction-type updates. It exposes all per-endpoint registers to the host CPU over a simple byte-wide register bus, and raises a level interrupt on completed or NAKed transactions.

---
 rtl/slave_endp_mux_pkg.sv | 40 ++++
 rtl/slave_endp_mux_if.sv | 37 +++
 rtl/slave_endp_regs.sv | 59 +++++
 rtl/slave_endp_mux.sv | 96 +++++++++
 tb/tb_slave_endp_mux.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/slave_endp_mux_pkg.sv
// Shared constants for the USB slave endpoint register bank: bit positions,
// register offsets and the per-cycle event bundle handed to every endpoint.
package slave_endp_mux_pkg;

    // CONTROL bits
    localparam int CTRL_ENABLE      = 0;
    localparam int CTRL_READY       = 1;
    localparam int CTRL_OUTDATA_SEQ = 2;
    localparam int CTRL_SEND_STALL  = 3;

    // STATUS bits
    localparam int ST_CRC      = 0;
    localparam int ST_BITSTUFF = 1;
    localparam int ST_OVERFLOW = 2;
    localparam int ST_TIMEOUT  = 3;
    localparam int ST_NAK      = 4;
    localparam int ST_STALL    = 5;

    // Register offsets within an endpoint
    localparam logic [1:0] REG_CONTROL = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_TYPE    = 2'd2;
    localparam logic [1:0] REG_INTR    = 2'd3;

    // INTR bits
    localparam int INTR_DONE = 0;
    localparam int INTR_NAK  = 1;

    // End-of-transaction strobes from the slave controller, broadcast to all
    // endpoints; each endpoint qualifies them with its own select.
    typedef struct packed {
        logic       clr_rdy;
        logic       err_wen;
        logic       trans_done;
        logic       nak_sent;
        logic [5:0] status;
        logic [3:0] types;
    } ep_evt_t;

endpackage

// File: rtl/slave_endp_mux_if.sv
// Controller-side and CPU-bus-side signals of the endpoint register bank.
interface slave_endp_mux_if;
    logic [3:0] USBEndP;
    logic [3:0] USBEndPControlReg;
    logic       clrEPRdy;
    logic       endPMuxErrorsWEn;
    logic       transDone;
    logic       CRCError;
    logic       bitStuffError;
    logic       RxOverflow;
    logic       RxTimeOut;
    logic       NAKSent;
    logic       stallSent;
    logic [1:0] USBEndPTransTypeReg;
    logic [1:0] USBEndPNakTransTypeReg;
    logic [5:0] busAddr;
    logic       busWEn;
    logic [7:0] busDataIn;
    logic [7:0] busDataOut;
    logic       slaveIntr;

    modport slave (
        input  USBEndP, clrEPRdy, endPMuxErrorsWEn, transDone,
               CRCError, bitStuffError, RxOverflow, RxTimeOut, NAKSent, stallSent,
               USBEndPTransTypeReg, USBEndPNakTransTypeReg,
               busAddr, busWEn, busDataIn,
        output USBEndPControlReg, busDataOut, slaveIntr
    );

    modport master (
        output USBEndP, clrEPRdy, endPMuxErrorsWEn, transDone,
               CRCError, bitStuffError, RxOverflow, RxTimeOut, NAKSent, stallSent,
               USBEndPTransTypeReg, USBEndPNakTransTypeReg,
               busAddr, busWEn, busDataIn,
        input  USBEndPControlReg, busDataOut, slaveIntr
    );
endinterface

// File: rtl/slave_endp_regs.sv
// One endpoint's CONTROL/STATUS/TYPE/INTR registers. Hardware events win over
// CPU writes where both touch the same bit in the same cycle.
module slave_endp_regs
    import slave_endp_mux_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sel_i,
    input  ep_evt_t    evt_i,
    input  logic       wr_ctrl_i,
    input  logic       wr_intr_i,
    input  logic [3:0] wdata_i,
    output logic [3:0] ctrl_o,
    output logic [5:0] status_o,
    output logic [3:0] type_o,
    output logic [1:0] intr_o
);
    logic [3:0] ctrl_q, ctrl_d;
    logic [5:0] status_q, status_d;
    logic [3:0] type_q, type_d;
    logic [1:0] intr_q, intr_d;

    // Next state: CPU write first, then hardware set/clear overrides it
    always_comb begin
        ctrl_d   = ctrl_q;
        status_d = status_q;
        type_d   = type_q;
        intr_d   = intr_q;
        if (wr_ctrl_i) ctrl_d = wdata_i;
        if (wr_intr_i) intr_d = intr_q & ~wdata_i[1:0];
        if (sel_i && evt_i.clr_rdy) ctrl_d[CTRL_READY] = 1'b0;
        if (sel_i && evt_i.err_wen) begin
            status_d = evt_i.status;
            type_d   = evt_i.types;
            if (evt_i.trans_done)    intr_d[INTR_DONE] = 1'b1;
            else if (evt_i.nak_sent) intr_d[INTR_NAK]  = 1'b1;
        end
    end

    // Register state, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q   <= '0;
            status_q <= '0;
            type_q   <= '0;
            intr_q   <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            type_q   <= type_d;
            intr_q   <= intr_d;
        end
    end

    assign ctrl_o   = ctrl_q;
    assign status_o = status_q;
    assign type_o   = type_q;
    assign intr_o   = intr_q;
endmodule

// File: rtl/slave_endp_mux.sv
// Endpoint register bank top: address decode, controller endpoint select and
// registered output muxes. Endpoints >= NUM_ENDPOINTS read as zero.
module slave_endp_mux
    import slave_endp_mux_pkg::*;
#(
    parameter int NUM_ENDPOINTS = 4
) (
    input  logic           clk,
    input  logic           rst,
    slave_endp_mux_if.slave ifc
);
    logic [NUM_ENDPOINTS-1:0][3:0] ctrl_w;
    logic [NUM_ENDPOINTS-1:0][5:0] status_w;
    logic [NUM_ENDPOINTS-1:0][3:0] type_w;
    logic [NUM_ENDPOINTS-1:0][1:0] intr_w;

    ep_evt_t    evt;
    logic [3:0] bus_ep;
    logic [1:0] bus_reg;
    logic [3:0] ctrl_out_q, ctrl_out_d;
    logic [7:0] rd_q, rd_d;
    logic       intr_q;
    logic       unused_bus_hi;

    assign bus_ep        = ifc.busAddr[5:2];
    assign bus_reg       = ifc.busAddr[1:0];
    assign unused_bus_hi = ^ifc.busDataIn[7:4];

    // Bundle the controller's end-of-transaction strobes
    always_comb begin
        evt                     = '0;
        evt.clr_rdy             = ifc.clrEPRdy;
        evt.err_wen             = ifc.endPMuxErrorsWEn;
        evt.trans_done          = ifc.transDone;
        evt.nak_sent            = ifc.NAKSent;
        evt.status[ST_CRC]      = ifc.CRCError;
        evt.status[ST_BITSTUFF] = ifc.bitStuffError;
        evt.status[ST_OVERFLOW] = ifc.RxOverflow;
        evt.status[ST_TIMEOUT]  = ifc.RxTimeOut;
        evt.status[ST_NAK]      = ifc.NAKSent;
        evt.status[ST_STALL]    = ifc.stallSent;
        evt.types               = {ifc.USBEndPNakTransTypeReg, ifc.USBEndPTransTypeReg};
    end

    for (genvar i = 0; i < NUM_ENDPOINTS; i++) begin : g_ep
        logic hit;
        assign hit = (bus_ep == 4'(i)) && ifc.busWEn;
        slave_endp_regs u_regs (
            .clk       (clk),
            .rst       (rst),
            .sel_i     (ifc.USBEndP == 4'(i)),
            .evt_i     (evt),
            .wr_ctrl_i (hit && (bus_reg == REG_CONTROL)),
            .wr_intr_i (hit && (bus_reg == REG_INTR)),
            .wdata_i   (ifc.busDataIn[3:0]),
            .ctrl_o    (ctrl_w[i]),
            .status_o  (status_w[i]),
            .type_o    (type_w[i]),
            .intr_o    (intr_w[i])
        );
    end

    // Controller select and CPU read mux; unmatched endpoints give zero
    always_comb begin
        ctrl_out_d = '0;
        rd_d       = '0;
        for (int i = 0; i < NUM_ENDPOINTS; i++) begin
            if (ifc.USBEndP == 4'(i)) ctrl_out_d = ctrl_w[i];
            if (bus_ep == 4'(i)) begin
                case (bus_reg)
                    REG_CONTROL: rd_d = {4'b0, ctrl_w[i]};
                    REG_STATUS:  rd_d = {2'b0, status_w[i]};
                    REG_TYPE:    rd_d = {4'b0, type_w[i]};
                    REG_INTR:    rd_d = {6'b0, intr_w[i]};
                endcase
            end
        end
    end

    // Registered outputs: control nibble, read data and interrupt level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_out_q <= '0;
            rd_q       <= '0;
            intr_q     <= 1'b0;
        end else begin
            ctrl_out_q <= ctrl_out_d;
            rd_q       <= rd_d;
            intr_q     <= |intr_w;
        end
    end

    assign ifc.USBEndPControlReg = ctrl_out_q;
    assign ifc.busDataOut        = rd_q;
    assign ifc.slaveIntr         = intr_q;
endmodule

// File: tb/tb_slave_endp_mux.sv
// Directed bench for slave_endp_mux with a register-map model checked every cycle.
module tb_slave_endp_mux;
    localparam int NEP = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;

    slave_endp_mux_if u_if ();
    slave_endp_mux #(.NUM_ENDPOINTS(NEP)) dut (.clk(clk), .rst(rst), .ifc(u_if.slave));

    always #5 clk = ~clk;

    // Model state: the register map as plain arrays
    logic [3:0] m_ctrl [16];
    logic [5:0] m_stat [16];
    logic [3:0] m_type [16];
    logic [1:0] m_intr [16];
    logic [3:0] e_ctrl = '0;
    logic [7:0] e_rd = '0;
    logic       e_int = 1'b0;
    int         mep, mbep, mbr;

    function automatic logic [7:0] m_read(int ep, int r);
        if (ep >= NEP) return 8'h00;
        case (r)
            0:       return {4'h0, m_ctrl[ep]};
            1:       return {2'b0, m_stat[ep]};
            2:       return {4'h0, m_type[ep]};
            default: return {6'b0, m_intr[ep]};
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                m_ctrl[i] = 0; m_stat[i] = 0; m_type[i] = 0; m_intr[i] = 0;
            end
            e_ctrl = 0; e_rd = 0; e_int = 0;
        end else begin
            mep  = int'(u_if.USBEndP);
            mbep = int'(u_if.busAddr[5:2]);
            mbr  = int'(u_if.busAddr[1:0]);
            e_ctrl = (mep < NEP) ? m_ctrl[mep] : 4'h0;
            e_rd   = m_read(mbep, mbr);
            e_int  = 1'b0;
            for (int i = 0; i < NEP; i++) if (m_intr[i] != 0) e_int = 1'b1;
            if (u_if.busWEn && mbep < NEP) begin
                if (mbr == 0) m_ctrl[mbep] = u_if.busDataIn[3:0];
                if (mbr == 3) m_intr[mbep] = m_intr[mbep] & ~u_if.busDataIn[1:0];
            end
            if (mep < NEP) begin
                if (u_if.clrEPRdy) m_ctrl[mep][1] = 1'b0;
                if (u_if.endPMuxErrorsWEn) begin
                    m_stat[mep] = {u_if.stallSent, u_if.NAKSent, u_if.RxTimeOut,
                                   u_if.RxOverflow, u_if.bitStuffError, u_if.CRCError};
                    m_type[mep] = {u_if.USBEndPNakTransTypeReg, u_if.USBEndPTransTypeReg};
                    if (u_if.transDone)    m_intr[mep][0] = 1'b1;
                    else if (u_if.NAKSent) m_intr[mep][1] = 1'b1;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_ctrl_out", {4'h0, u_if.USBEndPControlReg}, {4'h0, e_ctrl});
            check("model_rd", u_if.busDataOut, e_rd);
            check("model_intr", {7'h0, u_if.slaveIntr}, {7'h0, e_int});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        u_if.clrEPRdy = 0; u_if.endPMuxErrorsWEn = 0; u_if.transDone = 0;
        u_if.CRCError = 0; u_if.bitStuffError = 0; u_if.RxOverflow = 0; u_if.RxTimeOut = 0;
        u_if.NAKSent = 0; u_if.stallSent = 0;
        u_if.USBEndPTransTypeReg = 0; u_if.USBEndPNakTransTypeReg = 0;
        u_if.busWEn = 0; u_if.busDataIn = 0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [7:0] exp, input string nm);
        u_if.busAddr = a;
        cyc();
        check(nm, u_if.busDataOut, exp);
    endtask

    initial begin
        clear_in();
        u_if.USBEndP = 0;
        u_if.busAddr = 0;
        cyc(); cyc();
        check("rst_ctrl_out", {4'h0, u_if.USBEndPControlReg}, 8'h00);
        check("rst_rd", u_if.busDataOut, 8'h00);
        check("rst_intr", {7'h0, u_if.slaveIntr}, 8'h00);
        rst = 1'b1;
        chk_en = 1'b1;

        // ep1 CONTROL write, then select ep1
        u_if.busAddr = 6'h04; u_if.busDataIn = 8'h03; u_if.busWEn = 1;
        cyc();
        u_if.busWEn = 0; u_if.USBEndP = 1;
        cyc();
        check("sel_ep1_ctrl", {4'h0, u_if.USBEndPControlReg}, 8'h03);
        check("rd_ep1_ctrl", u_if.busDataOut, 8'h03);

        // clrEPRdy + completed transaction on ep1
        u_if.clrEPRdy = 1; u_if.endPMuxErrorsWEn = 1; u_if.transDone = 1;
        u_if.USBEndPTransTypeReg = 2;
        cyc();
        clear_in();
        check("intr_lag", {7'h0, u_if.slaveIntr}, 8'h00);
        u_if.busAddr = 6'h04;
        cyc();
        check("intr_set", {7'h0, u_if.slaveIntr}, 8'h01);
        check("ep1_ctrl_clr", u_if.busDataOut, 8'h01);
        rd(6'h06, 8'h02, "ep1_type");
        rd(6'h07, 8'h01, "ep1_intr");

        // NAKed transaction with CRC error on ep2
        u_if.USBEndP = 2; u_if.endPMuxErrorsWEn = 1; u_if.NAKSent = 1; u_if.CRCError = 1;
        u_if.USBEndPNakTransTypeReg = 1;
        cyc();
        clear_in();
        rd(6'h09, 8'h11, "ep2_status");
        rd(6'h0A, 8'h04, "ep2_type");
        rd(6'h0B, 8'h02, "ep2_intr");

        // write to a read-only register is ignored
        u_if.busAddr = 6'h0A; u_if.busDataIn = 8'hFF; u_if.busWEn = 1;
        cyc();
        u_if.busWEn = 0;
        rd(6'h0A, 8'h04, "ep2_type_ro");

        // CPU write + clrEPRdy same cycle: clear wins on READY
        u_if.USBEndP = 1;
        u_if.busAddr = 6'h04; u_if.busDataIn = 8'h0F; u_if.busWEn = 1; u_if.clrEPRdy = 1;
        cyc();
        clear_in();
        rd(6'h04, 8'h0D, "ctrl_clr_wins");

        // clear ep2 INTR, then W1C collides with a hardware set on ep1
        u_if.busAddr = 6'h0B; u_if.busDataIn = 8'h02; u_if.busWEn = 1;
        cyc();
        u_if.busAddr = 6'h07; u_if.busDataIn = 8'h01; u_if.busWEn = 1;
        u_if.endPMuxErrorsWEn = 1; u_if.transDone = 1;
        cyc();
        clear_in();
        rd(6'h07, 8'h01, "intr_set_wins");
        u_if.busDataIn = 8'h01; u_if.busWEn = 1;
        cyc();
        u_if.busWEn = 0;
        check("intr_hold", {7'h0, u_if.slaveIntr}, 8'h01);
        cyc();
        check("intr_drop", {7'h0, u_if.slaveIntr}, 8'h00);
        check("ep1_intr_w1c", u_if.busDataOut, 8'h00);

        // unimplemented endpoint 9
        u_if.USBEndP = 9;
        cyc();
        check("ep9_ctrl_out", {4'h0, u_if.USBEndPControlReg}, 8'h00);
        u_if.clrEPRdy = 1; u_if.endPMuxErrorsWEn = 1; u_if.transDone = 1;
        u_if.NAKSent = 1; u_if.CRCError = 1;
        u_if.busAddr = 6'h24; u_if.busDataIn = 8'h0F; u_if.busWEn = 1;
        cyc();
        clear_in();
        rd(6'h24, 8'h00, "ep9_rd");
        rd(6'h07, 8'h00, "ep1_intr_untouched");
        rd(6'h04, 8'h0D, "ep1_ctrl_untouched");
        for (int a = 0; a < 64; a++) begin
            u_if.busAddr = 6'(a);
            cyc();
        end

        // asynchronous reset mid-sequence
        u_if.USBEndP = 1; u_if.endPMuxErrorsWEn = 1; u_if.transDone = 1;
        u_if.busAddr = 6'h04;
        cyc();
        clear_in();
        cyc();
        check("pre_rst_intr", {7'h0, u_if.slaveIntr}, 8'h01);
        check("pre_rst_ctrl_out", {4'h0, u_if.USBEndPControlReg}, 8'h0D);
        #1 rst = 1'b0;
        #1;
        check("async_rst_ctrl_out", {4'h0, u_if.USBEndPControlReg}, 8'h00);
        check("async_rst_rd", u_if.busDataOut, 8'h00);
        check("async_rst_intr", {7'h0, u_if.slaveIntr}, 8'h00);
        cyc();
        rst = 1'b1;
        rd(6'h04, 8'h00, "post_rst_ctrl");
        rd(6'h07, 8'h00, "post_rst_intr");
        cyc();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
